jtcop_obj_dma: RTL and testbench

- Sequences the object table consumed by the sprite line engine.
- On a CPU DMA request it copies the 1024-word CPU-side object RAM into the back bank of an internal double-buffered table.
- The front and back banks swap at the start of vertical blank, and only when a full copy has completed.
- The line engine reads the front bank through tbl_addr/tbl_dout, so it never sees a partially copied table.

---
 rtl/jtcop_obj_pkg.sv | 28 ++
 rtl/jtcop_obj_dma_if.sv | 31 +++
 rtl/jtcop_obj_dbuf.sv | 41 ++++
 rtl/jtcop_obj_dma.sv | 150 +++++++++++++++
 tb/tb_jtcop_obj_dma.sv | 286 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/jtcop_obj_pkg.sv
// jtcop_obj_pkg: definitions shared by the object DMA sequencer and the
// sprite line engine.
//   - default table geometry (address width, word width)
//   - DMA sequencer state encoding
//   - bit positions of the fields inside an object table word
package jtcop_obj_pkg;

  localparam int OBJ_AW = 10;  // table depth 2**OBJ_AW words
  localparam int OBJ_DW = 16;  // table word width

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_PRIME = 2'd1,
    ST_COPY  = 2'd2,
    ST_FLUSH = 2'd3
  } dma_state_t;

  // Object word 0 layout, consumed by the line engine
  localparam int OBJ_YPOS_LSB  = 0;
  localparam int OBJ_YPOS_MSB  = 8;
  localparam int OBJ_MSIZE_LSB = 9;
  localparam int OBJ_MSIZE_MSB = 10;
  localparam int OBJ_NSIZE_LSB = 11;
  localparam int OBJ_NSIZE_MSB = 12;
  localparam int OBJ_FLIPX_BIT = 13;
  localparam int OBJ_FLIPY_BIT = 14;

endpackage

// File: rtl/jtcop_obj_dma_if.sv
// jtcop_obj_dma_if: memory-side buses of the object DMA block.
//   ram_addr / ram_dout : read port into the CPU-side object RAM
//                         (data valid one clk after the address)
//   tbl_addr / tbl_dout : line-engine read port into the front bank
//                         (registered, one clk latency)
// master = the DMA block, slave = the surroundings (CPU RAM + line engine).
interface jtcop_obj_dma_if
  import jtcop_obj_pkg::*;
#(
  parameter int AW = OBJ_AW,
  parameter int DW = OBJ_DW
);
  logic [AW-1:0] ram_addr;
  logic [DW-1:0] ram_dout;
  logic [AW-1:0] tbl_addr;
  logic [DW-1:0] tbl_dout;

  modport master (
    output ram_addr,
    input  ram_dout,
    input  tbl_addr,
    output tbl_dout
  );

  modport slave (
    input  ram_addr,
    output ram_dout,
    output tbl_addr,
    input  tbl_dout
  );
endinterface

// File: rtl/jtcop_obj_dbuf.sv
// jtcop_obj_dbuf: double-buffered object table, 2**(AW+1) x DW simple
// dual-port RAM. The write port always targets the back bank (~bank_i),
// the registered read port always targets the front bank (bank_i), so the
// two ports can never collide.
// Ports:
//   clk, rst   : clock, synchronous active-low reset (read register only)
//   bank_i     : current front bank
//   we_i/waddr_i/wdata_i : back-bank write
//   raddr_i/rdata_o      : front-bank read, one clk latency
module jtcop_obj_dbuf
  import jtcop_obj_pkg::*;
#(
  parameter int AW = OBJ_AW,
  parameter int DW = OBJ_DW
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          bank_i,
  input  logic          we_i,
  input  logic [AW-1:0] waddr_i,
  input  logic [DW-1:0] wdata_i,
  input  logic [AW-1:0] raddr_i,
  output logic [DW-1:0] rdata_o
);

  logic [DW-1:0] mem_q [0:(2**(AW+1))-1];
  logic [DW-1:0] rdata_q;

  // Table contents are deliberately left untouched by reset
  always_ff @(posedge clk) begin
    if (we_i) mem_q[{~bank_i, waddr_i}] <= wdata_i;
  end

  always_ff @(posedge clk) begin
    if (!rst) rdata_q <= '0;
    else      rdata_q <= mem_q[{bank_i, raddr_i}];
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/jtcop_obj_dma.sv
// jtcop_obj_dma: object table DMA sequencer.
// A dma_req copies the whole CPU object RAM into the back bank of a double
// buffered table; banks swap on the LVBL falling edge only after a complete
// copy, so the line engine never sees a partial table.
// Ports:
//   clk      : system clock
//   rst      : synchronous reset, active-low
//   LVBL     : vertical blank, active-low
//   dma_req  : one-cycle copy request
//   dma_busy : copy running or pending
//   bank     : current front bank
//   bus      : jtcop_obj_dma_if.master (CPU RAM read + line-engine read)
// Optional build macro JTCOP_OBJ_DMA_AUTO_EN: when defined, a copy is also
// started at the end of blank if no dma_req arrived during the frame.
module jtcop_obj_dma
  import jtcop_obj_pkg::*;
#(
  parameter int AW = OBJ_AW,
  parameter int DW = OBJ_DW
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            LVBL,
  input  logic            dma_req,
  output logic            dma_busy,
  output logic            bank,
  jtcop_obj_dma_if.master bus
);

  localparam logic [AW-1:0] ADDR_LAST = '1;
  localparam logic [AW-1:0] ADDR_ONE  = AW'(1);

  dma_state_t    state_q, state_d;
  logic [AW-1:0] ram_addr_q, ram_addr_d;
  logic          pending_q, pending_d;
  logic          copy_done_q, copy_done_d;
  logic          bank_q, bank_d;
  logic          lvbl_q;

  logic          lvbl_fall;
  logic          start_req;
  logic          we;
  logic [AW-1:0] waddr;

  assign lvbl_fall = lvbl_q & ~LVBL;

`ifdef JTCOP_OBJ_DMA_AUTO_EN
  logic lvbl_rise;
  logic req_seen_q, req_seen_d;

  assign lvbl_rise = ~lvbl_q & LVBL;
  // Frame-long memory of whether the CPU asked for a copy itself
  assign req_seen_d = dma_req ? 1'b1 : (lvbl_fall ? 1'b0 : req_seen_q);
  assign start_req  = dma_req | (lvbl_rise & ~req_seen_q);

  always_ff @(posedge clk) begin
    if (!rst) req_seen_q <= 1'b0;
    else      req_seen_q <= req_seen_d;
  end
`else
  assign start_req = dma_req;
`endif

  always_comb begin
    state_d     = state_q;
    ram_addr_d  = ram_addr_q;
    pending_d   = pending_q;
    copy_done_d = copy_done_q;
    bank_d      = bank_q;
    we          = 1'b0;
    waddr       = ram_addr_q - ADDR_ONE;

    // Requests during a copy collapse into one restart
    if (state_q != ST_IDLE && start_req) pending_d = 1'b1;

    // Swap uses copy_done before this cycle's update, so a copy finishing
    // in the same cycle as the blank edge waits for the next frame
    if (lvbl_fall && copy_done_q) begin
      bank_d      = ~bank_q;
      copy_done_d = 1'b0;
    end

    unique case (state_q)
      ST_IDLE: begin
        if (start_req || pending_q) begin
          state_d     = ST_PRIME;
          ram_addr_d  = '0;
          copy_done_d = 1'b0;
          pending_d   = 1'b0;
        end
      end
      ST_PRIME: begin
        // Word 0 is on its way from the CPU RAM; request word 1 meanwhile
        ram_addr_d = ADDR_ONE;
        state_d    = ST_COPY;
      end
      ST_COPY: begin
        // ram_dout belongs to the previous address
        we = 1'b1;
        if (ram_addr_q == ADDR_LAST) state_d    = ST_FLUSH;
        else                         ram_addr_d = ram_addr_q + ADDR_ONE;
      end
      ST_FLUSH: begin
        we          = 1'b1;
        waddr       = ADDR_LAST;
        copy_done_d = 1'b1;
        ram_addr_d  = '0;
        state_d     = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q     <= ST_IDLE;
      ram_addr_q  <= '0;
      pending_q   <= 1'b0;
      copy_done_q <= 1'b0;
      bank_q      <= 1'b0;
      lvbl_q      <= 1'b1;
    end else begin
      state_q     <= state_d;
      ram_addr_q  <= ram_addr_d;
      pending_q   <= pending_d;
      copy_done_q <= copy_done_d;
      bank_q      <= bank_d;
      lvbl_q      <= LVBL;
    end
  end

  assign bus.ram_addr = ram_addr_q;
  assign dma_busy     = (state_q != ST_IDLE) | pending_q;
  assign bank         = bank_q;

  jtcop_obj_dbuf #(
    .AW (AW),
    .DW (DW)
  ) u_dbuf (
    .clk     (clk),
    .rst     (rst),
    .bank_i  (bank_q),
    .we_i    (we),
    .waddr_i (waddr),
    .wdata_i (bus.ram_dout),
    .raddr_i (bus.tbl_addr),
    .rdata_o (bus.tbl_dout)
  );

endmodule

// File: tb/tb_jtcop_obj_dma.sv
// Bench for jtcop_obj_dma. The reference model keeps both table banks as
// plain arrays: a completed copy snapshots the CPU RAM into the back bank,
// a blank falling edge swaps only after a completed copy, reset returns to
// bank 0 and forgets any copy in flight.
module tb_jtcop_obj_dma;
  import jtcop_obj_pkg::*;

  localparam int AW = 10;
  localparam int DW = 16;
  localparam int N  = 1 << AW;
  localparam int BUDGET = 6000;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic LVBL = 1'b1;
  logic dma_req = 1'b0;
  logic dma_busy;
  logic bank;

  jtcop_obj_dma_if #(.AW(AW), .DW(DW)) bus ();

  jtcop_obj_dma #(.AW(AW), .DW(DW)) dut (
    .clk      (clk),
    .rst      (rst),
    .LVBL     (LVBL),
    .dma_req  (dma_req),
    .dma_busy (dma_busy),
    .bank     (bank),
    .bus      (bus)
  );

  always #5 clk = ~clk;

  // CPU object RAM: one clk read latency
  logic [DW-1:0] cpu_mem [0:N-1];
  always @(posedge clk) bus.ram_dout <= cpu_mem[bus.ram_addr];

  // Reference model
  logic [DW-1:0] m_tbl [0:1][0:N-1];
  bit            m_valid [0:1];
  bit            m_bank;
  bit            m_done;

  int checks = 0;
  int errors = 0;

  task automatic m_copy_complete();
    int back = m_bank ? 0 : 1;
    for (int i = 0; i < N; i++) m_tbl[back][i] = cpu_mem[i];
    m_valid[back] = 1'b1;
    m_done = 1'b1;
  endtask

  task automatic m_fall();
    if (m_done) begin
      m_bank = ~m_bank;
      m_done = 1'b0;
    end
  endtask

  task automatic fill_random();
    for (int i = 0; i < N; i++) cpu_mem[i] = DW'($urandom);
  endtask

  task automatic pulse_req();
    @(negedge clk) dma_req = 1'b1;
    @(negedge clk) dma_req = 1'b0;
  endtask

  task automatic blank_edge();
    @(negedge clk) LVBL = 1'b0;
    repeat (3) @(negedge clk);
    LVBL = 1'b1;
    @(negedge clk);
  endtask

  task automatic read_tbl(input logic [AW-1:0] a, output logic [DW-1:0] d);
    @(negedge clk) bus.tbl_addr = a;
    @(negedge clk) d = bus.tbl_dout;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    repeat (3) @(negedge clk);
    m_bank = 1'b0; m_done = 1'b0;
    checks++; if (dma_busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", dma_busy); end
    checks++; if (bank !== 1'b0) begin errors++; $display("FAIL reset_bank got %b want 0", bank); end
    checks++; if (bus.ram_addr !== '0) begin errors++; $display("FAIL reset_ram_addr got %0d want 0", bus.ram_addr); end
    checks++; if (bus.tbl_dout !== '0) begin errors++; $display("FAIL reset_tbl_dout got %h want 0", bus.tbl_dout); end
    rst = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_copy_swap();
    int cyc;
    logic [DW-1:0] d;
    logic [AW-1:0] a;
    for (int i = 0; i < N; i++) cpu_mem[i] = DW'(i) ^ 16'hA5A5;
    pulse_req();
    cyc = 0;
    while (dma_busy && cyc < BUDGET) begin @(negedge clk); cyc++; end
    m_copy_complete();
    checks++; if (cyc != N + 1) begin errors++; $display("FAIL copy_busy_cycles got %0d want %0d", cyc, N + 1); end
    checks++; if (bank !== m_bank) begin errors++; $display("FAIL copy_bank_before_blank got %b want %b", bank, m_bank); end
    blank_edge();
    m_fall();
    checks++; if (bank !== m_bank || m_bank !== 1'b1) begin errors++; $display("FAIL copy_swap got %b want 1", bank); end
    read_tbl(AW'(3), d);
    checks++; if (d !== 16'hA5A6) begin errors++; $display("FAIL copy_tbl3 got %h want a5a6", d); end
    for (int k = 0; k < 8; k++) begin
      a = AW'($urandom_range(N - 1));
      read_tbl(a, d);
      checks++; if (d !== m_tbl[m_bank][a]) begin errors++; $display("FAIL copy_read[%0d] got %h want %h", a, d, m_tbl[m_bank][a]); end
    end
    read_tbl(AW'(N - 1), d);
    checks++; if (d !== m_tbl[m_bank][N-1]) begin errors++; $display("FAIL copy_last_word got %h want %h", d, m_tbl[m_bank][N-1]); end
  endtask

  task automatic test_no_copy();
    logic [DW-1:0] d;
    for (int f = 0; f < 2; f++) begin
      blank_edge();
      m_fall();
      repeat (2) @(negedge clk);
`ifndef JTCOP_OBJ_DMA_AUTO_EN
      checks++; if (dma_busy !== 1'b0) begin errors++; $display("FAIL nocopy_busy[%0d] got %b want 0", f, dma_busy); end
`endif
      checks++; if (bank !== m_bank) begin errors++; $display("FAIL nocopy_bank[%0d] got %b want %b", f, bank, m_bank); end
      read_tbl(AW'(3), d);
      checks++; if (d !== m_tbl[m_bank][3]) begin errors++; $display("FAIL nocopy_tbl[%0d] got %h want %h", f, d, m_tbl[m_bank][3]); end
    end
  endtask

  task automatic test_req_during_copy();
    int cyc;
    logic [DW-1:0] d;
    logic [AW-1:0] a;
    fill_random();
    pulse_req();
    cyc = 0;
    while (dma_busy && cyc < BUDGET) begin
      dma_req = (cyc == 200 || cyc == 600);
      if (cyc == 700) begin
        cpu_mem[5]   = ~cpu_mem[5];
        cpu_mem[N-1] = DW'($urandom);
      end
      @(negedge clk);
      cyc++;
    end
    dma_req = 1'b0;
    m_copy_complete();
    checks++; if (cyc != 2 * N + 3) begin errors++; $display("FAIL pend_busy_cycles got %0d want %0d", cyc, 2 * N + 3); end
    blank_edge();
    m_fall();
    checks++; if (bank !== m_bank) begin errors++; $display("FAIL pend_swap got %b want %b", bank, m_bank); end
    read_tbl(AW'(5), d);
    checks++; if (d !== cpu_mem[5]) begin errors++; $display("FAIL pend_late_write got %h want %h", d, cpu_mem[5]); end
    for (int k = 0; k < 6; k++) begin
      a = AW'($urandom_range(N - 1));
      read_tbl(a, d);
      checks++; if (d !== m_tbl[m_bank][a]) begin errors++; $display("FAIL pend_read[%0d] got %h want %h", a, d, m_tbl[m_bank][a]); end
    end
  endtask

  task automatic test_blank_mid_copy();
    int cyc;
    logic [DW-1:0] d;
    logic [AW-1:0] a;
    fill_random();
    pulse_req();
    cyc = 0;
    while (dma_busy && cyc < BUDGET) begin
      if (cyc == 500) LVBL = 1'b0;
      if (cyc == 504) LVBL = 1'b1;
      if (cyc == 502) begin
        m_fall();
        checks++; if (bank !== m_bank) begin errors++; $display("FAIL midblank_bank got %b want %b", bank, m_bank); end
      end
      @(negedge clk);
      cyc++;
    end
    LVBL = 1'b1;
    checks++; if (cyc != N + 1) begin errors++; $display("FAIL midblank_busy_cycles got %0d want %0d", cyc, N + 1); end
    m_copy_complete();
    blank_edge();
    m_fall();
    checks++; if (bank !== m_bank) begin errors++; $display("FAIL midblank_next_swap got %b want %b", bank, m_bank); end
    for (int k = 0; k < 6; k++) begin
      a = AW'($urandom_range(N - 1));
      read_tbl(a, d);
      checks++; if (d !== m_tbl[m_bank][a]) begin errors++; $display("FAIL midblank_read[%0d] got %h want %h", a, d, m_tbl[m_bank][a]); end
    end
  endtask

  task automatic test_reset_mid_copy();
    int cyc;
    logic [DW-1:0] d;
    logic [AW-1:0] a;
    // Make bank 0 the front bank so the partially written bank is bank 1
    cyc = 0;
    while (m_bank && cyc < 2) begin
      fill_random();
      pulse_req();
      cyc = 0;
      while (dma_busy && cyc < BUDGET) begin @(negedge clk); cyc++; end
      m_copy_complete();
      blank_edge();
      m_fall();
      cyc = 0;
    end
    checks++; if (bank !== m_bank || m_bank !== 1'b0) begin errors++; $display("FAIL rstmid_prep_bank got %b want 0", bank); end
    fill_random();
    pulse_req();
    for (cyc = 0; cyc < 300; cyc++) begin
      dma_req = (cyc == 200);
      @(negedge clk);
    end
    dma_req = 1'b0;
    rst = 1'b0;
    @(negedge clk);
    m_bank = 1'b0; m_done = 1'b0; m_valid[1] = 1'b0;
    checks++; if (dma_busy !== 1'b0) begin errors++; $display("FAIL rstmid_busy got %b want 0", dma_busy); end
    checks++; if (bank !== m_bank) begin errors++; $display("FAIL rstmid_bank got %b want %b", bank, m_bank); end
    rst = 1'b1;
    repeat (4) @(negedge clk);
    checks++; if (dma_busy !== 1'b0) begin errors++; $display("FAIL rstmid_pending_dropped got %b want 0", dma_busy); end
    blank_edge();
    m_fall();
    checks++; if (bank !== m_bank) begin errors++; $display("FAIL rstmid_no_swap got %b want %b", bank, m_bank); end
    for (int k = 0; k < 6; k++) begin
      a = AW'($urandom_range(N - 1));
      read_tbl(a, d);
      checks++; if (d !== m_tbl[0][a]) begin errors++; $display("FAIL rstmid_read[%0d] got %h want %h", a, d, m_tbl[0][a]); end
    end
  endtask

`ifdef JTCOP_OBJ_DMA_AUTO_EN
  task automatic test_auto();
    int cyc;
    logic [DW-1:0] d;
    fill_random();
    @(negedge clk) LVBL = 1'b0;
    repeat (3) @(negedge clk);
    m_fall();
    LVBL = 1'b1;
    @(negedge clk);
    checks++; if (dma_busy !== 1'b1) begin errors++; $display("FAIL auto_start got %b want 1", dma_busy); end
    cyc = 0;
    while (dma_busy && cyc < BUDGET) begin @(negedge clk); cyc++; end
    checks++; if (cyc >= BUDGET) begin errors++; $display("FAIL auto_done got %0d want <%0d", cyc, BUDGET); end
    m_copy_complete();
    @(negedge clk) LVBL = 1'b0;
    repeat (2) @(negedge clk);
    m_fall();
    checks++; if (bank !== m_bank) begin errors++; $display("FAIL auto_swap got %b want %b", bank, m_bank); end
    LVBL = 1'b1;
    read_tbl(AW'(7), d);
    checks++; if (d !== m_tbl[m_bank][7]) begin errors++; $display("FAIL auto_read got %h want %h", d, m_tbl[m_bank][7]); end
  endtask
`endif

  initial begin
    bus.tbl_addr = '0;
    m_bank = 1'b0; m_done = 1'b0;
    m_valid[0] = 1'b0; m_valid[1] = 1'b0;
    for (int i = 0; i < N; i++) cpu_mem[i] = '0;
    test_reset();
    test_copy_swap();
    test_no_copy();
    test_req_during_copy();
    test_blank_mid_copy();
    test_reset_mid_copy();
`ifdef JTCOP_OBJ_DMA_AUTO_EN
    test_auto();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #5000000;
    $display("FAIL global_timeout got running want finished");
    $fatal(1, "bench timeout");
  end

endmodule
